// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Byte-serial instruction fetch; assembles a little-endian word and
//            hands it to decode over valid/ready. Owns the PC.
// Revision : 1.0
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0]  c_LAST_BYTE = 2'd3;
    localparam logic [31:0] c_WORD_STEP = 32'd4;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_byte_cnt <= 2'd0;
            r_instr    <= 32'd0;
        end else if (redirect_valid) begin
            // Redirect wins over a same-cycle handshake: pc is not advanced.
            r_pc       <= {redirect_target[31:2], 2'b00};
            r_byte_cnt <= 2'd0;
            r_state    <= fetch_en ? S_FETCH : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_byte_cnt <= 2'd0;
                    if (fetch_en) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_instr[{r_byte_cnt, 3'b000} +: 8] <= mem_rdata;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    if (r_byte_cnt == c_LAST_BYTE) begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        r_pc    <= r_pc + c_WORD_STEP;
                        r_state <= fetch_en ? S_FETCH : S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_byte_cnt <= 2'd0;
                end
            endcase
        end
    end

    assign mem_addr    = r_pc + {30'b0, r_byte_cnt};
    assign instr_pc    = r_pc;
    assign instr_out   = r_instr;
    assign instr_valid = (r_state == S_HOLD);
    assign busy        = (r_state == S_FETCH);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Table-driven bench for fetch_sequencer with an accept scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic        acc;
        logic [31:0] e_addr;
        logic        e_busy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_word;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } txn_t;

    vec_t tbl[$];
    txn_t sb[$];

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image; unlisted addresses return a hash of the address.
    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 8'h93;
            32'h0000_0001: return 8'h00;
            32'h0000_0002: return 8'h40;
            32'h0000_0003: return 8'h06;
            32'h0000_0004: return 8'h13;
            32'h0000_0005: return 8'h01;
            32'h0000_0006: return 8'h80;
            32'h0000_0007: return 8'h0C;
            32'h0000_0014: return 8'h23;
            32'h0000_0015: return 8'hA0;
            32'h0000_0016: return 8'h11;
            32'h0000_0017: return 8'h00;
            32'h0000_0028: return 8'h83;
            32'h0000_0029: return 8'h82;
            32'h0000_002A: return 8'h81;
            32'h0000_002B: return 8'h00;
            32'hFFFF_FFFC: return 8'hEF;
            32'hFFFF_FFFD: return 8'hBE;
            32'hFFFF_FFFE: return 8'hAD;
            32'hFFFF_FFFF: return 8'hDE;
            default:       return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_rd(a + 32'd3), mem_rd(a + 32'd2), mem_rd(a + 32'd1), mem_rd(a)};
    endfunction

    always_comb mem_rdata = mem_rd(mem_addr);

    function automatic vec_t mk(input logic rst, input logic en, input logic rv,
                                input logic [31:0] tgt, input logic rdy, input logic acc,
                                input logic [31:0] e_addr, input logic e_busy,
                                input logic e_valid, input logic [31:0] e_pc,
                                input logic [31:0] e_word);
        vec_t v;
        v.rst = rst; v.en = en; v.rv = rv; v.tgt = tgt; v.rdy = rdy; v.acc = acc;
        v.e_addr = e_addr; v.e_busy = e_busy; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_word = e_word;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Checks this cycle's outputs, drives this cycle's inputs, then scores any handshake.
    task automatic step(input string tag, input vec_t v);
        txn_t t;
        @(negedge clk);
        chk({tag, " mem_addr"},    mem_addr,           v.e_addr);
        chk({tag, " busy"},        {31'd0, busy},        {31'd0, v.e_busy});
        chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, v.e_valid});
        chk({tag, " instr_pc"},    instr_pc,           v.e_pc);
        if (v.e_valid) chk({tag, " instr_out"}, instr_out, v.e_word);
        reset           = v.rst;
        fetch_en        = v.en;
        redirect_valid  = v.rv;
        redirect_target = v.tgt;
        instr_ready     = v.rdy;
        if (v.acc) begin
            t.pc = v.e_pc; t.word = v.e_word;
            sb.push_back(t);
        end
        if (!reset && !redirect_valid && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                chk({tag, " sb_unexpected_accept"}, 32'd1, 32'd0);
            end else begin
                t = sb.pop_front();
                chk({tag, " sb_pc"},   instr_pc,  t.pc);
                chk({tag, " sb_word"}, instr_out, t.word);
            end
        end
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'd0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Sequential fetch with ready high, then backpressure on the second word
        tbl.push_back(mk(0,1,0,0,1,0, 32'h0,0,0,32'h0,0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0,1,0,0,1,0, k,1,0,32'h0,0));
        tbl.push_back(mk(0,1,0,0,1,1, 32'h0,0,1,32'h0,32'h0640_0093));
        for (int k = 4; k < 8; k++) tbl.push_back(mk(0,1,0,0,1,0, k,1,0,32'h4,0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0,1,0,0,0,0, 32'h4,0,1,32'h4,32'h0C80_0113));
        tbl.push_back(mk(0,0,0,0,1,1, 32'h4,0,1,32'h4,32'h0C80_0113));
        // fetch_en low after accept: remain idle
        tbl.push_back(mk(0,0,0,0,1,0, 32'h8,0,0,32'h8,0));
        tbl.push_back(mk(0,0,0,0,1,0, 32'h8,0,0,32'h8,0));
        tbl.push_back(mk(0,1,0,0,1,0, 32'h8,0,0,32'h8,0));
        tbl.push_back(mk(0,1,0,0,1,0, 32'h8,1,0,32'h8,0));
        tbl.push_back(mk(0,1,0,0,1,0, 32'h9,1,0,32'h8,0));
        // Redirect mid-word (byte_cnt = 2) to an unaligned target
        tbl.push_back(mk(0,1,1,32'h2A,1,0, 32'hA,1,0,32'h8,0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0,1,0,0,1,0, 32'h28 + k,1,0,32'h28,0));
        // Redirect together with ready in HOLD: word dropped, no pc advance
        tbl.push_back(mk(0,1,1,32'h14,1,0, 32'h28,0,1,32'h28,32'h0081_8283));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0,1,0,0,1,0, 32'h14 + k,1,0,32'h14,0));
        tbl.push_back(mk(0,1,0,0,1,1, 32'h14,0,1,32'h14,32'h0011_A023));
        // Address wrap at the top of memory
        tbl.push_back(mk(0,1,1,32'hFFFF_FFFF,1,0, 32'h18,1,0,32'h18,0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0,1,0,0,1,0, 32'hFFFF_FFFC + k,1,0,32'hFFFF_FFFC,0));
        tbl.push_back(mk(0,0,0,0,1,1, 32'hFFFF_FFFC,0,1,32'hFFFF_FFFC,32'hDEAD_BEEF));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,0,0,32'h0,0));

        foreach (tbl[i]) step($sformatf("row%0d", i), tbl[i]);

        // Reset in FETCH with byte_cnt = 1
        step("rf0", mk(0,1,1,32'h40,0,0, 32'h0,0,0,32'h0,0));
        step("rf1", mk(0,1,0,0,0,0, 32'h40,1,0,32'h40,0));
        step("rf2", mk(1,1,0,0,0,0, 32'h41,1,0,32'h40,0));
        step("rf3", mk(0,0,0,0,0,0, 32'h0,0,0,32'h0,0));

        // Reset in HOLD, with ready asserted in the same cycle
        step("rh0", mk(0,1,1,32'h83,0,0, 32'h0,0,0,32'h0,0));
        for (int k = 0; k < 4; k++)
            step($sformatf("rh%0d", k + 1), mk(0,1,0,0,0,0, 32'h80 + k,1,0,32'h80,0));
        step("rh5", mk(0,1,0,0,0,0, 32'h80,0,1,32'h80,word_at(32'h80)));
        step("rh6", mk(1,1,0,0,1,0, 32'h80,0,1,32'h80,word_at(32'h80)));
        step("rh7", mk(0,0,0,0,0,0, 32'h0,0,0,32'h0,0));
        step("rh8", mk(0,0,0,0,0,0, 32'h0,0,0,32'h0,0));

        chk("sb_leftover", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
